// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, issues imem reads, and parks on the HALT word until redirected or reset.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        stall,
    input  logic        flush_if,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    logic [31:0] w_pc4;
    logic [31:0] w_redirect_aligned;
    logic        w_is_halt;

    // pc[1:0] is kept zero, so pc+4 stays aligned and wraps modulo 2^32.
    assign w_pc4              = r_pc + 32'd4;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign w_is_halt          = (imemload == HALT_WORD);

    assign imemREN    = (r_state == S_FETCH) && !RST;
    assign imemaddr   = r_pc;
    assign instr_id   = r_instr_id;
    assign pc4_id     = r_pc4_id;
    assign valid_id   = r_valid_id;
    assign halted     = (r_state == S_HALT);
    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_FETCH;
            r_pc         <= {PC_INIT[31:2], 2'b00};
            r_instr_id   <= '0;
            r_pc4_id     <= '0;
            r_valid_id   <= 1'b0;
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (redirect) begin
            // Redirect also squashes a speculatively fetched halt.
            r_pc         <= w_redirect_aligned;
            r_state      <= S_FETCH;
            r_valid_id   <= 1'b0;
            r_instr_id   <= '0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else if (flush_if) begin
            r_valid_id   <= 1'b0;
            r_instr_id   <= '0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else if (stall) begin
            // Everything holds; a word returned now is dropped and refetched.
            r_pc <= r_pc;
        end else if (r_state == S_FETCH && ihit) begin
            r_instr_id  <= imemload;
            r_pc4_id    <= w_pc4;
            r_valid_id  <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_is_halt) begin
                r_state <= S_HALT;
            end else begin
                r_pc <= w_pc4;
            end
        end else begin
            // FETCH waiting on memory, or parked in HALT: insert a bubble.
            r_valid_id   <= 1'b0;
            r_instr_id   <= '0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: streaming, wait states, stall, redirect,
// flush, halt, PC wrap and reset, with hand-computed expectations.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        stall;
    logic        flush_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .imemload   (imemload),
        .ihit       (ihit),
        .stall      (stall),
        .flush_if   (flush_if),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_id   (instr_id),
        .pc4_id     (pc4_id),
        .valid_id   (valid_id),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid, input logic [31:0] e_addr);
        check({tag, ".instr_id"}, instr_id, e_instr);
        check({tag, ".pc4_id"}, pc4_id, e_pc4);
        check({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, e_valid});
        check({tag, ".imemaddr"}, imemaddr, e_addr);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] e_fetch, input logic [31:0] e_bubble);
        check({tag, ".fetch_cnt"}, fetch_cnt, e_fetch);
        check({tag, ".bubble_cnt"}, bubble_cnt, e_bubble);
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
        flush_if = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset
        step();
        check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
        check_cnt("rst", 32'd0, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.imemREN", {31'd0, imemREN}, 32'd0);

        // Zero-wait stream
        RST = 1'b0; ihit = 1'b1; imemload = 32'h2001_0001;
        #1;
        check("s0.imemREN", {31'd0, imemREN}, 32'd1);
        check("s0.imemaddr", imemaddr, 32'h0);
        step();
        check_ifid("s1", 32'h2001_0001, 32'h4, 1'b1, 32'h4);
        imemload = 32'h2002_0002;
        step();
        check_ifid("s2", 32'h2002_0002, 32'h8, 1'b1, 32'h8);
        check_cnt("s2", 32'd2, 32'd0);
        imemload = 32'h0000_0000;
        step();
        imemload = 32'h1111_1111;
        step();
        check_ifid("s4", 32'h1111_1111, 32'h10, 1'b1, 32'h10);

        // Wait states at 0x10
        ihit = 1'b0;
        step();
        check_ifid("w1", 32'h0, 32'h10, 1'b0, 32'h10);
        step();
        check_ifid("w2", 32'h0, 32'h10, 1'b0, 32'h10);
        check_cnt("w2", 32'd4, 32'd2);
        ihit = 1'b1; imemload = 32'h2222_2222;
        step();
        check_ifid("w3", 32'h2222_2222, 32'h14, 1'b1, 32'h14);
        check_cnt("w3", 32'd5, 32'd2);

        // Fill to pc=0x20 with 0x8C220000 in IF/ID
        imemload = 32'h3333_3333; step();
        imemload = 32'h4444_4444; step();
        imemload = 32'h8C22_0000; step();
        check_ifid("pre_stall", 32'h8C22_0000, 32'h20, 1'b1, 32'h20);
        check_cnt("pre_stall", 32'd8, 32'd2);

        // Stall three cycles with ihit=1
        stall = 1'b1; imemload = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid($sformatf("stall%0d", i), 32'h8C22_0000, 32'h20, 1'b1, 32'h20);
            check_cnt($sformatf("stall%0d", i), 32'd8, 32'd2);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", 32'h5555_5555, 32'h24, 1'b1, 32'h24);
        check_cnt("unstall", 32'd9, 32'd2);

        // Redirect beats stall; low bits of target dropped
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        check_ifid("redir", 32'h0, 32'h24, 1'b0, 32'h100);
        check_cnt("redir", 32'd9, 32'd3);
        redirect = 1'b0; stall = 1'b0;

        // Flush discards the returned word and refetches
        flush_if = 1'b1; imemload = 32'h6666_6666;
        step();
        check_ifid("flush", 32'h0, 32'h24, 1'b0, 32'h100);
        check_cnt("flush", 32'd9, 32'd4);
        flush_if = 1'b0;

        // Halt at 0x40
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0; imemload = 32'hFFFF_FFFF;
        step();
        check_ifid("halt0", 32'hFFFF_FFFF, 32'h44, 1'b1, 32'h40);
        check("halt0.halted", {31'd0, halted}, 32'd1);
        check("halt0.imemREN", {31'd0, imemREN}, 32'd0);
        check_cnt("halt0", 32'd10, 32'd5);
        imemload = 32'h7777_7777;
        step();
        check_ifid("halt1", 32'h0, 32'h44, 1'b0, 32'h40);
        check("halt1.halted", {31'd0, halted}, 32'd1);
        check_cnt("halt1", 32'd10, 32'd6);
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        check("unhalt.halted", {31'd0, halted}, 32'd0);
        check("unhalt.imemREN", {31'd0, imemREN}, 32'd1);
        check("unhalt.imemaddr", imemaddr, 32'h80);
        check_cnt("unhalt", 32'd10, 32'd7);

        // Halt word during stall is dropped, then refetched
        stall = 1'b1; imemload = 32'hFFFF_FFFF;
        step();
        check("hstall.halted", {31'd0, halted}, 32'd0);
        check_ifid("hstall", 32'h0, 32'h44, 1'b0, 32'h80);
        stall = 1'b0;
        step();
        check("hrefetch.halted", {31'd0, halted}, 32'd1);
        check_ifid("hrefetch", 32'hFFFF_FFFF, 32'h84, 1'b1, 32'h80);
        check_cnt("hrefetch", 32'd11, 32'd7);

        // PC wrap at 0xFFFFFFFC
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap0.halted", {31'd0, halted}, 32'd0);
        check("wrap0.imemaddr", imemaddr, 32'hFFFF_FFFC);
        imemload = 32'h1234_5678;
        step();
        check_ifid("wrap1", 32'h1234_5678, 32'h0, 1'b1, 32'h0);
        check_cnt("wrap1", 32'd12, 32'd8);

        // Reset while a request is pending
        ihit = 1'b0;
        step();
        check_cnt("pend", 32'd12, 32'd9);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("pend.imemaddr", imemaddr, 32'h200);
        RST = 1'b1;
        #1;
        check("rst2.imemREN_pre", {31'd0, imemREN}, 32'd0);
        step();
        check_ifid("rst2", 32'h0, 32'h0, 1'b0, 32'h0);
        check_cnt("rst2", 32'd0, 32'd0);
        check("rst2.halted", {31'd0, halted}, 32'd0);
        check("rst2.imemREN", {31'd0, imemREN}, 32'd0);
        ihit = 1'b1; imemload = 32'hAAAA_AAAA; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        check_ifid("rst3", 32'h0, 32'h0, 1'b0, 32'h0);
        check_cnt("rst3", 32'd0, 32'd0);
        RST = 1'b0; redirect = 1'b0; imemload = 32'hBBBB_BBBB;
        #1;
        check("post_rst.imemREN", {31'd0, imemREN}, 32'd1);
        step();
        check_ifid("post_rst", 32'hBBBB_BBBB, 32'h4, 1'b1, 32'h4);
        check_cnt("post_rst", 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
